// File: rtl/proc_datapath.sv
// Datapath of the 16-bit teaching processor: 16x16 register file, 256x16 data memory,
// write-back mux and an 8-function ALU. Reads are combinational; writes land on the rising edge.
module proc_datapath (
    input  logic        Clock,
    input  logic        Reset,
    input  logic [7:0]  D_Addr,
    input  logic        D_Wr,
    input  logic        RF_s,
    input  logic [3:0]  RF_W_Addr,
    input  logic        RF_W_en,
    input  logic [3:0]  RF_Ra_Addr,
    input  logic [3:0]  RF_Rb_Addr,
    input  logic [2:0]  ALU_s0,
    output logic [15:0] ALU_inA,
    output logic [15:0] ALU_inB,
    output logic [15:0] ALU_out
);
    typedef enum logic [2:0] {
        OP_ZERO = 3'd0,
        OP_ADD  = 3'd1,
        OP_SUB  = 3'd2,
        OP_PASS = 3'd3,
        OP_XOR  = 3'd4,
        OP_OR   = 3'd5,
        OP_AND  = 3'd6,
        OP_INC  = 3'd7
    } alu_op_e;

    logic [15:0] rf  [16];
    logic [15:0] mem [256] = '{default: 16'h0000};
    logic [15:0] mem_rdata;
    logic [15:0] w_data;

    assign ALU_inA   = rf[RF_Ra_Addr];
    assign ALU_inB   = rf[RF_Rb_Addr];
    assign mem_rdata = mem[D_Addr];
    assign w_data    = RF_s ? mem_rdata : ALU_out;

    always_comb begin
        ALU_out = 16'h0000;
        case (alu_op_e'(ALU_s0))
            OP_ZERO: ALU_out = 16'h0000;
            OP_ADD:  ALU_out = ALU_inA + ALU_inB;
            OP_SUB:  ALU_out = ALU_inA - ALU_inB;
            OP_PASS: ALU_out = ALU_inA;
            OP_XOR:  ALU_out = ALU_inA ^ ALU_inB;
            OP_OR:   ALU_out = ALU_inA | ALU_inB;
            OP_AND:  ALU_out = ALU_inA & ALU_inB;
            OP_INC:  ALU_out = ALU_inA + 16'h0001;
            default: ALU_out = 16'h0000;
        endcase
    end

    // Reset wins over a pending register write; the old operand feeds w_data, so no loop forms.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            for (int i = 0; i < 16; i++) rf[i] <= 16'h0000;
        end else if (RF_W_en) begin
            rf[RF_W_Addr] <= w_data;
        end
    end

    // Memory ignores Reset; a store in the reset cycle still uses the pre-reset operand.
    always_ff @(posedge Clock) begin
        if (D_Wr) mem[D_Addr] <= ALU_inA;
    end
endmodule

// File: tb/tb_proc_datapath.sv
// Randomized and directed checks of proc_datapath against an array-based behavioural model.
module tb_proc_datapath;
    logic        Clock = 1'b0;
    logic        Reset;
    logic [7:0]  D_Addr;
    logic        D_Wr;
    logic        RF_s;
    logic [3:0]  RF_W_Addr;
    logic        RF_W_en;
    logic [3:0]  RF_Ra_Addr;
    logic [3:0]  RF_Rb_Addr;
    logic [2:0]  ALU_s0;
    logic [15:0] ALU_inA;
    logic [15:0] ALU_inB;
    logic [15:0] ALU_out;

    int n_tests = 0;
    int n_fail  = 0;

    logic [15:0] m_rf  [16];
    logic [15:0] m_mem [256];

    proc_datapath dut (
        .Clock(Clock), .Reset(Reset), .D_Addr(D_Addr), .D_Wr(D_Wr), .RF_s(RF_s),
        .RF_W_Addr(RF_W_Addr), .RF_W_en(RF_W_en), .RF_Ra_Addr(RF_Ra_Addr),
        .RF_Rb_Addr(RF_Rb_Addr), .ALU_s0(ALU_s0), .ALU_inA(ALU_inA),
        .ALU_inB(ALU_inB), .ALU_out(ALU_out)
    );

    always #5 Clock = ~Clock;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] alu_ref(input int op, input int a, input int b);
        int r;
        case (op)
            1: r = a + b;
            2: r = a - b;
            3: r = a;
            4: r = a ^ b;
            5: r = a | b;
            6: r = a & b;
            7: r = a + 1;
            default: r = 0;
        endcase
        return r[15:0];
    endfunction

    task automatic idle();
        Reset = 0; D_Wr = 0; RF_s = 0; RF_W_en = 0;
        D_Addr = 0; RF_W_Addr = 0; RF_Ra_Addr = 0; RF_Rb_Addr = 0; ALU_s0 = 0;
    endtask

    // Check combinational outputs against the model, then clock once and advance the model.
    task automatic tick(input string tag);
        logic [15:0] ea, eb, eo, wd;
        #1;
        ea = m_rf[RF_Ra_Addr];
        eb = m_rf[RF_Rb_Addr];
        eo = alu_ref(int'(ALU_s0), int'(ea), int'(eb));
        chk({tag, ".inA"}, ALU_inA, ea);
        chk({tag, ".inB"}, ALU_inB, eb);
        chk({tag, ".out"}, ALU_out, eo);
        wd = RF_s ? m_mem[D_Addr] : eo;
        @(posedge Clock);
        if (Reset) for (int i = 0; i < 16; i++) m_rf[i] = 16'h0000;
        else if (RF_W_en) m_rf[RF_W_Addr] = wd;
        if (D_Wr) m_mem[D_Addr] = ea;
        #1;
    endtask

    task automatic read_chk(input string tag, input logic [3:0] r, input logic [15:0] exp);
        idle();
        RF_Ra_Addr = r;
        #1;
        chk(tag, ALU_inA, exp);
    endtask

    // Build a constant by doubling (A+A) and incrementing, MSB first.
    task automatic load_const(input logic [3:0] r, input logic [15:0] v);
        idle(); RF_W_Addr = r; RF_W_en = 1; ALU_s0 = 3'd0;
        tick("ldc");
        for (int i = 15; i >= 0; i--) begin
            idle(); RF_W_Addr = r; RF_W_en = 1; RF_Ra_Addr = r; RF_Rb_Addr = r; ALU_s0 = 3'd1;
            tick("ldc");
            if (v[i]) begin
                idle(); RF_W_Addr = r; RF_W_en = 1; RF_Ra_Addr = r; ALU_s0 = 3'd7;
                tick("ldc");
            end
        end
        read_chk("ldc.val", r, v);
    endtask

    task automatic store(input logic [7:0] a, input logic [3:0] r);
        idle(); D_Addr = a; RF_Ra_Addr = r; D_Wr = 1;
        tick("st");
    endtask

    task automatic load(input logic [7:0] a, input logic [3:0] r);
        idle(); D_Addr = a; RF_s = 1; RF_W_en = 1; RF_W_Addr = r;
        tick("ld");
    endtask

    logic [15:0] sweep_exp [8];

    initial begin
        for (int i = 0; i < 16; i++) m_rf[i] = 16'h0000;
        for (int i = 0; i < 256; i++) m_mem[i] = 16'h0000;
        sweep_exp[0] = 16'h0000; sweep_exp[1] = 16'h0000; sweep_exp[2] = 16'h0002;
        sweep_exp[3] = 16'h8001; sweep_exp[4] = 16'hFFFE; sweep_exp[5] = 16'hFFFF;
        sweep_exp[6] = 16'h0001; sweep_exp[7] = 16'h8002;

        idle(); Reset = 1;
        @(posedge Clock); #1;
        idle();
        #1;
        chk("rst.inA", ALU_inA, 16'h0000);
        chk("rst.inB", ALU_inB, 16'h0000);
        ALU_s0 = 3'd7; #1;
        chk("rst.op7", ALU_out, 16'h0001);
        ALU_s0 = 3'd1; #1;
        chk("rst.op1", ALU_out, 16'h0000);

        // Random phase: mixed writes, stores, loads, occasional reset
        for (int n = 0; n < 400; n++) begin
            idle();
            Reset      = ($urandom_range(0, 31) == 0);
            D_Wr       = $urandom_range(0, 1);
            RF_s       = $urandom_range(0, 1);
            RF_W_en    = ($urandom_range(0, 3) != 0);
            RF_W_Addr  = $urandom_range(0, 15);
            RF_Ra_Addr = $urandom_range(0, 15);
            RF_Rb_Addr = $urandom_range(0, 15);
            ALU_s0     = $urandom_range(0, 7);
            D_Addr     = $urandom_range(0, 1) ? 8'($urandom_range(0, 15)) : 8'($urandom_range(0, 255));
            tick("rnd");
        end

        // Reset clears everything, and overrides a same-cycle write to R3
        load_const(4'd3, 16'h5A5A);
        idle(); Reset = 1; RF_W_en = 1; RF_W_Addr = 4'd3; RF_Ra_Addr = 4'd3; ALU_s0 = 3'd3;
        tick("rstw");
        for (int i = 0; i < 16; i++) read_chk($sformatf("rst.R%0d", i), 4'(i), 16'h0000);

        // Store then load through memory
        load_const(4'd2, 16'h1234);
        store(8'h05, 4'd2);
        load(8'h05, 4'd7);
        read_chk("load.R7", 4'd7, 16'h1234);

        // ALU sweep with write-back
        load_const(4'd4, 16'h8001);
        load_const(4'd5, 16'h7FFF);
        for (int op = 0; op < 8; op++) begin
            idle(); RF_Ra_Addr = 4'd4; RF_Rb_Addr = 4'd5; ALU_s0 = 3'(op);
            RF_W_en = 1; RF_W_Addr = 4'd6;
            #1;
            chk($sformatf("sweep.out%0d", op), ALU_out, sweep_exp[op]);
            tick("sweep");
            read_chk($sformatf("sweep.R6_%0d", op), 4'd6, sweep_exp[op]);
        end

        // Self-referential increment wrapping FFFF -> 0000
        load_const(4'd1, 16'hFFFF);
        idle(); RF_Ra_Addr = 4'd1; ALU_s0 = 3'd7; RF_W_en = 1; RF_W_Addr = 4'd1;
        #1;
        chk("inc.pre", ALU_out, 16'h0000);
        chk("inc.old", ALU_inA, 16'hFFFF);
        tick("inc");
        read_chk("inc.R1", 4'd1, 16'h0000);

        // Same-cycle store and load at 10h: load sees the old word
        load_const(4'd8, 16'hAAAA);
        store(8'h10, 4'd8);
        load_const(4'd9, 16'h5555);
        idle(); D_Addr = 8'h10; D_Wr = 1; RF_Ra_Addr = 4'd9; RF_s = 1; RF_W_en = 1; RF_W_Addr = 4'd10;
        tick("stld");
        read_chk("stld.R10", 4'd10, 16'hAAAA);
        load(8'h10, 4'd11);
        read_chk("stld.mem", 4'd11, 16'h5555);

        // Address extremes
        store(8'h01, 4'd8);
        store(8'hFE, 4'd9);
        load_const(4'd0, 16'h0F0F);
        load_const(4'd15, 16'hF00F);
        load_const(4'd1, 16'h1111);
        load_const(4'd14, 16'hEEEE);
        store(8'h00, 4'd0);
        store(8'hFF, 4'd15);
        load(8'h00, 4'd12);
        read_chk("ext.M00", 4'd12, 16'h0F0F);
        load(8'hFF, 4'd13);
        read_chk("ext.MFF", 4'd13, 16'hF00F);
        load(8'h01, 4'd12);
        read_chk("ext.M01", 4'd12, 16'hAAAA);
        load(8'hFE, 4'd13);
        read_chk("ext.MFE", 4'd13, 16'h5555);
        read_chk("ext.R0", 4'd0, 16'h0F0F);
        read_chk("ext.R15", 4'd15, 16'hF00F);
        read_chk("ext.R1", 4'd1, 16'h1111);
        read_chk("ext.R14", 4'd14, 16'hEEEE);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
